zx_ram_arbiter: RTL and testbench
=================================

ZX_RAM_ARBITER -- requirements
Module: zx_ram_arbiter

Interface
REQ-001 Parameter VID_BASE, default 2'b01, is the upper two RAM address bits applied to every video fetch (screen page 0x4000).
REQ-002 Parameter CPU_MAX_WAIT, default 2, is the number of consecutive video grants after which a pending CPU request wins.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cpu_req  input  1  CPU access request; held high with stable cpu_we/addr/din until cpu_ack.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  16  CPU byte address.
REQ-008 cpu_din  input  8  CPU write data.
REQ-009 cpu_ack  output  1  one-cycle completion pulse.
REQ-010 cpu_dout  output  8  read data; valid in the cpu_ack cycle, held until the next CPU read completes.
REQ-011 vid_req  input  1  one-cycle video fetch request pulse.
REQ-012 vid_addr  input  14  screen-relative byte address; sampled with vid_req.
REQ-013 vid_valid  output  1  one-cycle pulse; vid_data valid.
REQ-014 vid_data  output  8  fetched byte; held until the next video fetch completes.
REQ-015 vid_ovr  output  1  sticky overrun flag; cleared only by reset.
REQ-016 ram_we  output  1  write strobe to the byte-wide RAM port.
REQ-017 ram_addr  output  16  RAM byte address.
REQ-018 ram_din  output  8  RAM write data.
REQ-019 ram_dout  input  8  RAM read data; valid the cycle after address issue, and only while ram_addr is held unchanged (byte-lane select is combinational on ram_addr[0] and ram_addr[14]).

Function
REQ-020 The block SHALL implement states IDLE, V_ISS, V_DAT, C_ISS and C_DAT.
REQ-021 Every access SHALL take exactly two cycles: ISS presents the address; DAT holds the same ram_addr and captures ram_dout.
REQ-022 ram_we SHALL be high only in C_ISS with cpu_we=1, and low in every other state.
REQ-023 A vid_req pulse SHALL be latched into a one-deep pending register with its address.
REQ-024 A vid_req arriving while a fetch is already pending and not yet issued SHALL set vid_ovr and overwrite the pending address.
REQ-025 A vid_req arriving in the cycle that V_ISS consumes the pending entry SHALL be accepted as a new pending entry, not an overrun.
REQ-026 From IDLE or either DAT state, the next state SHALL be V_ISS if video is pending, else C_ISS if cpu_req is high and cpu_ack was not pulsed this cycle, else IDLE; transitions are back-to-back with no idle cycle.
REQ-027 Exception: when video and CPU are both pending and the video-grant counter equals CPU_MAX_WAIT, C_ISS SHALL win.
REQ-028 The video-grant counter SHALL count consecutive V_ISS entries while cpu_req is high, saturate at CPU_MAX_WAIT, and clear on C_ISS entry or when cpu_req is low.
REQ-029 In V_ISS and V_DAT, ram_addr SHALL be {VID_BASE, pending address}.
REQ-030 In C_ISS and C_DAT, ram_addr SHALL be cpu_addr and ram_din SHALL be cpu_din.
REQ-031 In IDLE, ram_addr SHALL hold its last value and ram_din SHALL be 0.
REQ-032 cpu_ack SHALL pulse in the cycle after C_DAT (registered), and cpu_dout SHALL update then on reads only.
REQ-033 vid_valid SHALL pulse in the cycle after V_DAT, with vid_data registered from ram_dout.
REQ-034 CPU-read latency SHALL be 3 cycles from grant to ack when uncontended; the worst-case CPU wait SHALL be 2*CPU_MAX_WAIT+3 cycles.

Reset
REQ-035 Reset SHALL force IDLE and clear the pending video entry, the counter, and vid_ovr.
REQ-036 Reset SHALL force ram_we=0, ram_addr=0, ram_din=0, cpu_ack=0, cpu_dout=0, vid_valid=0 and vid_data=0.
REQ-037 Reset asserted mid-access SHALL abort the access with no ack or valid pulse; a write already issued in C_ISS is not retracted.

Structure
REQ-038 The state encoding and default parameter values SHALL live in a shared package zx_mem_pkg.
REQ-039 The block SHALL be a single module with no sub-modules; the RAM wrapper is instantiated by the parent.

Verification
REQ-040 Bench RAM model SHALL have one-cycle read latency with combinational lane select on the current address.
REQ-041 Scenario: CPU write 0xA5 to 0x4001, then read 0x4001 -> ram_we high for exactly 1 cycle; cpu_dout=0xA5 at the second cpu_ack, 3 cycles after grant.
REQ-042 Scenario: vid_req with vid_addr=0x0000 while cpu_req is held -> V_ISS first, ram_addr=0x4000; vid_valid then cpu_ack follow.
REQ-043 Scenario: vid_req every 2 cycles with cpu_req held, CPU_MAX_WAIT=2 -> CPU granted after exactly 2 video accesses; vid_ovr stays 0.
REQ-044 Scenario: two vid_req pulses 1 cycle apart while a CPU access is in C_ISS -> vid_ovr=1 and only the second address is fetched.
REQ-045 Scenario: rst_n low in C_DAT of a read -> no cpu_ack, all outputs 0 next cycle; re-held cpu_req completes normally after release.
REQ-046 Scenario: vid_addr=0x1AFF preloaded with 0x3C -> vid_data=0x3C and ram_addr=0x5AFF stable across both V_ISS and V_DAT.

Source files
------------

// File: rtl/zx_mem_pkg.sv
// Shared definitions for the ZX RAM arbiter: FSM state encoding, default
// parameter values and the video address helper.
package zx_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_V_ISS = 3'd1,
      ST_V_DAT = 3'd2,
      ST_C_ISS = 3'd3,
      ST_C_DAT = 3'd4
   } arb_state_t;

   localparam logic [1:0]  VID_BASE_DEF     = 2'b01;
   localparam int unsigned CPU_MAX_WAIT_DEF = 32'd2;

   // Video fetches live in a fixed 16 KiB page selected by the two base bits.
   function automatic logic [15:0] vid_ram_addr(input logic [1:0] base, input logic [13:0] addr);
      return {base, addr};
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_wait);
      if (max_wait < 32'd1) begin
         return 32'd1;
      end else begin
         return $clog2(max_wait + 32'd1);
      end
   endfunction

endpackage

// File: rtl/zx_ram_arbiter_if.sv
// Bus bundle between the arbiter, its CPU/video clients and the RAM wrapper.
// slave = arbiter view, master = client/RAM view.
interface zx_ram_arbiter_if;

   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_ack;
   logic [7:0]  cpu_dout;

   logic        vid_req;
   logic [13:0] vid_addr;
   logic        vid_valid;
   logic [7:0]  vid_data;
   logic        vid_ovr;

   logic        ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_din,
      input  vid_req, vid_addr,
      input  ram_dout,
      output cpu_ack, cpu_dout,
      output vid_valid, vid_data, vid_ovr,
      output ram_we, ram_addr, ram_din
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_din,
      output vid_req, vid_addr,
      output ram_dout,
      input  cpu_ack, cpu_dout,
      input  vid_valid, vid_data, vid_ovr,
      input  ram_we, ram_addr, ram_din
   );

endinterface

// File: rtl/zx_ram_arbiter.sv
// Two-cycle-per-access arbiter sharing one byte-wide RAM port between the CPU
// and the video fetcher; video has priority, bounded by CPU_MAX_WAIT grants.
module zx_ram_arbiter
   import zx_mem_pkg::*;
#(
   parameter logic [1:0]  VID_BASE     = VID_BASE_DEF,
   parameter int unsigned CPU_MAX_WAIT = CPU_MAX_WAIT_DEF
) (
   input logic             clk,
   input logic             rst_n,
   zx_ram_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W   = cnt_width(CPU_MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   arb_state_t       state_r;
   arb_state_t       next_s;
   logic             cpu_pend_s;
   logic             cpu_first_s;
   logic [15:0]      ram_addr_s;
   logic [7:0]       ram_din_s;
   logic             ram_we_s;

   logic             vid_pend_r;
   logic [13:0]      vid_paddr_r;
   logic             vid_ovr_r;
   logic [CNT_W-1:0] cnt_r;

   logic             ram_we_r;
   logic [15:0]      ram_addr_r;
   logic [7:0]       ram_din_r;
   logic             cpu_ack_r;
   logic [7:0]       cpu_dout_r;
   logic             vid_valid_r;
   logic [7:0]       vid_data_r;

   // Arbitration: the CPU is not re-granted while its ack is being produced.
   always_comb begin
      cpu_pend_s  = bus.cpu_req && (state_r != ST_C_DAT) && !cpu_ack_r;
      cpu_first_s = cpu_pend_s && (cnt_r == CNT_MAX);
      next_s      = state_r;
      case (state_r)
         ST_IDLE, ST_V_DAT, ST_C_DAT: begin
            if (vid_pend_r && !cpu_first_s) begin
               next_s = ST_V_ISS;
            end else if (cpu_pend_s) begin
               next_s = ST_C_ISS;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_V_ISS: next_s = ST_V_DAT;
         ST_C_ISS: next_s = ST_C_DAT;
         default:  next_s = ST_IDLE;
      endcase
   end

   // RAM port values for the state being entered; a same-cycle vid_req overwrites the issue address.
   always_comb begin
      ram_addr_s = ram_addr_r;
      ram_din_s  = 8'h00;
      ram_we_s   = 1'b0;
      case (next_s)
         ST_V_ISS: begin
            if (bus.vid_req) begin
               ram_addr_s = vid_ram_addr(VID_BASE, bus.vid_addr);
            end else begin
               ram_addr_s = vid_ram_addr(VID_BASE, vid_paddr_r);
            end
         end
         ST_C_ISS: begin
            ram_addr_s = bus.cpu_addr;
            ram_din_s  = bus.cpu_din;
            ram_we_s   = bus.cpu_we;
         end
         ST_C_DAT: begin
            ram_addr_s = bus.cpu_addr;
            ram_din_s  = bus.cpu_din;
         end
         ST_V_DAT, ST_IDLE: ram_addr_s = ram_addr_r;
         default:           ram_addr_s = ram_addr_r;
      endcase
   end

   // State register, registered RAM port and client result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         ram_we_r    <= 1'b0;
         ram_addr_r  <= 16'h0000;
         ram_din_r   <= 8'h00;
         cpu_ack_r   <= 1'b0;
         cpu_dout_r  <= 8'h00;
         vid_valid_r <= 1'b0;
         vid_data_r  <= 8'h00;
      end else begin
         state_r     <= next_s;
         ram_we_r    <= ram_we_s;
         ram_addr_r  <= ram_addr_s;
         ram_din_r   <= ram_din_s;
         cpu_ack_r   <= (state_r == ST_C_DAT);
         vid_valid_r <= (state_r == ST_V_DAT);
         if ((state_r == ST_C_DAT) && !bus.cpu_we) begin
            cpu_dout_r <= bus.ram_dout;
         end else begin
            cpu_dout_r <= cpu_dout_r;
         end
         if (state_r == ST_V_DAT) begin
            vid_data_r <= bus.ram_dout;
         end else begin
            vid_data_r <= vid_data_r;
         end
      end
   end

   // One-deep video pending entry and sticky overrun flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vid_pend_r  <= 1'b0;
         vid_paddr_r <= 14'h0000;
         vid_ovr_r   <= 1'b0;
      end else begin
         if (bus.vid_req) begin
            vid_pend_r  <= 1'b1;
            vid_paddr_r <= bus.vid_addr;
            if (vid_pend_r && (state_r != ST_V_ISS)) begin
               vid_ovr_r <= 1'b1;
            end else begin
               vid_ovr_r <= vid_ovr_r;
            end
         end else if (state_r == ST_V_ISS) begin
            vid_pend_r  <= 1'b0;
            vid_paddr_r <= vid_paddr_r;
            vid_ovr_r   <= vid_ovr_r;
         end else begin
            vid_pend_r  <= vid_pend_r;
            vid_paddr_r <= vid_paddr_r;
            vid_ovr_r   <= vid_ovr_r;
         end
      end
   end

   // Consecutive video grants seen by a waiting CPU, saturating at CPU_MAX_WAIT.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (!bus.cpu_req) begin
         cnt_r <= '0;
      end else if (next_s == ST_C_ISS) begin
         cnt_r <= '0;
      end else if ((next_s == ST_V_ISS) && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign bus.ram_we    = ram_we_r;
   assign bus.ram_addr  = ram_addr_r;
   assign bus.ram_din   = ram_din_r;
   assign bus.cpu_ack   = cpu_ack_r;
   assign bus.cpu_dout  = cpu_dout_r;
   assign bus.vid_valid = vid_valid_r;
   assign bus.vid_data  = vid_data_r;
   assign bus.vid_ovr   = vid_ovr_r;

endmodule

// File: tb/tb_zx_ram_arbiter.sv
// Directed bench for zx_ram_arbiter with a one-cycle-latency RAM model whose
// byte-lane select follows the current address combinationally.
module tb_zx_ram_arbiter;

   logic clk;
   logic rst_n;
   zx_ram_arbiter_if bus();

   zx_ram_arbiter #(.VID_BASE(2'b01), .CPU_MAX_WAIT(32'd2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: contents default to addr[7:0]^addr[15:8], with 0x5AFF preloaded to 0x3C.
   logic [7:0]  mem [0:65535];
   logic [13:0] grp_r;
   bit          init_done;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 65536; i++) mem[i] <= 8'(i) ^ 8'(i >> 8);
         mem[16'h5AFF] <= 8'h3C;
         init_done     <= 1'b1;
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_din;
      end
      grp_r <= {bus.ram_addr[15], bus.ram_addr[13:1]};
   end

   assign bus.ram_dout = mem[{grp_r[13], bus.ram_addr[14], grp_r[12:0], bus.ram_addr[0]}];

   int          n_cmp;
   int          n_err;
   int          ack_k, first_v, nv, nv_pre, we_n;
   logic [7:0]  ack_dout, vdata, we_din;
   logic [15:0] ra_tr [0:31];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs n cycles from an idle point: raises cpu_req at cycle cpu_at, pulses vid_req on vmask bits.
   task automatic watch(input int n, input int cpu_at, input logic [31:0] vmask,
                        input logic [13:0] va0, input logic [13:0] va1, input logic [13:0] va2);
      int vp;
      vp = 0; ack_k = -1; first_v = -1; nv = 0; nv_pre = -1; we_n = 0;
      ack_dout = 8'h00; vdata = 8'h00; we_din = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (i == cpu_at) bus.cpu_req = 1'b1;
         if (vmask[i]) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = (vp == 0) ? va0 : ((vp == 1) ? va1 : va2);
            vp++;
         end else begin
            bus.vid_req = 1'b0;
         end
         step();
         ra_tr[i+1] = bus.ram_addr;
         if (bus.ram_we) begin
            we_n++;
            we_din = bus.ram_din;
         end
         if (bus.vid_valid) begin
            nv++;
            vdata = bus.vid_data;
            if (first_v < 0) first_v = i + 1;
         end
         if (bus.cpu_ack) begin
            if (ack_k < 0) begin
               ack_k    = i + 1;
               ack_dout = bus.cpu_dout;
               nv_pre   = nv;
            end
            bus.cpu_req = 1'b0;
         end
      end
      bus.vid_req = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_din = 8'h00;
      bus.vid_req = 1'b0; bus.vid_addr = 14'h0000;
      repeat (3) step();
      check_val("rst_ram_we",    32'(bus.ram_we),    32'd0);
      check_val("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
      check_val("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
      check_val("rst_vid_valid", 32'(bus.vid_valid), 32'd0);
      check_val("rst_vid_ovr",   32'(bus.vid_ovr),   32'd0);
      rst_n = 1'b1;
      step();

      // CPU write 0xA5 -> 0x4001
      bus.cpu_we = 1'b1; bus.cpu_addr = 16'h4001; bus.cpu_din = 8'hA5;
      watch(6, 0, 32'h0, 14'h0, 14'h0, 14'h0);
      check_val("wr_ack_lat",   32'(ack_k),    32'd3);
      check_val("wr_we_cycles", 32'(we_n),     32'd1);
      check_val("wr_ram_din",   32'(we_din),   32'hA5);
      check_val("wr_ram_addr",  32'(ra_tr[1]), 32'h4001);
      check_val("wr_dout_hold", 32'(ack_dout), 32'h00);

      // CPU read back 0x4001
      bus.cpu_we = 1'b0; bus.cpu_din = 8'h00;
      watch(6, 0, 32'h0, 14'h0, 14'h0, 14'h0);
      check_val("rd_ack_lat", 32'(ack_k),    32'd3);
      check_val("rd_dout",    32'(ack_dout), 32'hA5);
      check_val("rd_no_we",   32'(we_n),     32'd0);

      // Video pending before CPU: video goes first
      bus.cpu_addr = 16'h1234;
      watch(10, 1, 32'h1, 14'h0000, 14'h0, 14'h0);
      check_val("v1_iss_addr", 32'(ra_tr[2]), 32'h4000);
      check_val("v1_dat_addr", 32'(ra_tr[3]), 32'h4000);
      check_val("v1_valid_at", 32'(first_v),  32'd4);
      check_val("v1_vdata",    32'(vdata),    32'h40);
      check_val("v1_ack_at",   32'(ack_k),    32'd6);
      check_val("v1_cpu_dout", 32'(ack_dout), 32'h26);
      check_val("v1_order",    32'(nv_pre),   32'd1);

      // Video stream every 2 cycles: CPU wins after two video grants
      bus.cpu_addr = 16'h8001;
      watch(14, 1, 32'h15, 14'h0010, 14'h0011, 14'h0012);
      check_val("mw_vid_before_ack", 32'(nv_pre),   32'd2);
      check_val("mw_ack_at",         32'(ack_k),    32'd8);
      check_val("mw_cpu_dout",       32'(ack_dout), 32'h81);
      check_val("mw_cpu_addr",       32'(ra_tr[6]), 32'h8001);
      check_val("mw_third_addr",     32'(ra_tr[8]), 32'h4012);
      check_val("mw_vid_total",      32'(nv),       32'd3);
      check_val("mw_last_vdata",     32'(vdata),    32'h52);
      check_val("mw_no_ovr",         32'(bus.vid_ovr), 32'd0);

      // Preloaded screen byte, address stable across ISS and DAT
      watch(8, -1, 32'h1, 14'h1AFF, 14'h0, 14'h0);
      check_val("pl_iss_addr", 32'(ra_tr[2]), 32'h5AFF);
      check_val("pl_dat_addr", 32'(ra_tr[3]), 32'h5AFF);
      check_val("pl_valid_at", 32'(first_v),  32'd4);
      check_val("pl_vdata",    32'(vdata),    32'h3C);

      // Two video pulses during a CPU access: overrun, second address wins
      bus.cpu_addr = 16'h4001;
      watch(10, 0, 32'h6, 14'h0100, 14'h0222, 14'h0);
      check_val("ov_flag",     32'(bus.vid_ovr), 32'd1);
      check_val("ov_fetches",  32'(nv),          32'd1);
      check_val("ov_iss_addr", 32'(ra_tr[3]),    32'h4222);
      check_val("ov_dat_addr", 32'(ra_tr[4]),    32'h4222);
      check_val("ov_vdata",    32'(vdata),       32'h60);
      check_val("ov_ack_at",   32'(ack_k),       32'd3);
      check_val("ov_cpu_dout", 32'(ack_dout),    32'hA5);

      // Reset during C_DAT of a read aborts it; held request completes afterwards
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h4001; bus.cpu_req = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      step();
      check_val("ra_cpu_ack",   32'(bus.cpu_ack),   32'd0);
      check_val("ra_cpu_dout",  32'(bus.cpu_dout),  32'd0);
      check_val("ra_vid_ovr",   32'(bus.vid_ovr),   32'd0);
      check_val("ra_vid_data",  32'(bus.vid_data),  32'd0);
      check_val("ra_vid_valid", 32'(bus.vid_valid), 32'd0);
      check_val("ra_ram_addr",  32'(bus.ram_addr),  32'd0);
      check_val("ra_ram_din",   32'(bus.ram_din),   32'd0);
      check_val("ra_ram_we",    32'(bus.ram_we),    32'd0);
      rst_n = 1'b1;
      watch(6, -1, 32'h0, 14'h0, 14'h0, 14'h0);
      check_val("ra_retry_ack",  32'(ack_k),    32'd3);
      check_val("ra_retry_dout", 32'(ack_dout), 32'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
